count_snapshot: RTL and testbench
=================================

# count_snapshot

Downstream consumer of the dual 64-bit counter block. On a one-cycle trigger it captures both counter values (Output0/Output1 of the counter) into a small snapshot FIFO, then streams each snapshot out as four 32-bit words over a valid/ready handshake. It sits between the counter and any narrow readout path (UART/bus bridge), decoupling sampling instants from readout rate.

## Interface

- DEPTH, 4, snapshot FIFO entries; power of two, ≥2
- AW, 2, log2(DEPTH); must match DEPTH
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-low reset
- Cnt0  input  64  counter 0 value (from counter Output0)
- Cnt1  input  64  counter 1 value (from counter Output1)
- Trig  input  1  snapshot request, sampled each rising edge
- OutReady  input  1  downstream accepts word
- OutValid  output  1  OutData holds a valid word
- OutData  output  32  current word
- OutLast  output  1  high with the 4th word of a snapshot
- Level  output  AW+1  occupied FIFO entries (0..DEPTH)
- Full  output  1  Level == DEPTH
- Overflow  output  1  sticky: a trigger was dropped
- DropCnt  output  8  dropped triggers, saturates at 255

## Operation

- Push: at an edge with Trig=1 and Full=0, entry {Cnt1, Cnt0} written at write pointer; pointer wraps mod DEPTH.
- Trig=1 while Full=1: entry not written, Overflow←1, DropCnt increments unless already 255. Full is evaluated before any same-edge pop: a head frame completing on that edge does not make room for that trigger.
- Output FSM, two states:
  - IDLE: OutValid=0. Go to SEND when Level≠0.
  - SEND: word index W (0..3) selects Cnt0[31:0], Cnt0[63:32], Cnt1[31:0], Cnt1[63:32] of head entry. OutLast = (W==3).
  - Handshake: a word transfers on an edge with OutValid=1 and OutReady=1. Then W←W+1. On transfer at W=3: W←0, head popped, read pointer wraps mod DEPTH; stay in SEND if Level after pop ≠0, else IDLE.
  - While OutValid=1 and OutReady=0, OutData/OutLast stay stable. OutValid is never withdrawn before transfer.
- Simultaneous push and pop on the same edge: Level unchanged, both pointers advance.
- Level counts whole snapshots; a partially sent head counts as occupied until its 4th word transfers.
- Overflow and DropCnt are cleared only by reset.

## Timing

- Reset asserted (any time, including mid-frame): immediately OutValid=0, OutData=0, OutLast=0, Level=0, Full=0, Overflow=0, DropCnt=0, pointers=0, W=0, FSM=IDLE. Partial frames are discarded. Deassertion is synchronized externally.
- Push-to-output latency: Trig at edge N into empty FIFO → OutValid=1 with word 0 after edge N+1 (one registered cycle for FSM entry).
- Full throughput with OutReady held high: one word per cycle, 4 cycles per snapshot. Back-to-back snapshots have no idle cycle between them.
- Level, Full, Overflow and DropCnt are registered and update on the edge of the event.
- OutData is registered or driven from registered state only; it has no combinational path from Trig or Cnt*.

## Configuration

- COUNT_SNAPSHOT_DELTA_EN defined: each stored entry is {Cnt1−P1, Cnt0−P0} mod 2^64. P0/P1 are the raw values of the last accepted snapshot; they reset to 0, so the first snapshot equals the absolute value. Dropped triggers do not update P0/P1.
- Undefined: absolute values are stored and the P0/P1 registers are not present.

## Test plan

- Reset, Cnt0=64'h0000_0001_0000_0002, Cnt1=64'hAAAA_BBBB_CCCC_DDDD, one Trig, OutReady=1 → OutValid one edge later; words 0000_0002, 0000_0001, CCCC_DDDD, AAAA_BBBB with OutLast on the 4th; Level 1→0.
- OutReady=0, 5 triggers with DEPTH=4 → Level=4, Full=1, Overflow=1, DropCnt=1. Then OutReady=1 → 16 words in trigger order, no gaps.
- Backpressure: toggle OutReady every cycle mid-frame → OutData is stable during every stall; exactly 4 transfers per snapshot.
- Full FIFO with a Trig on the same edge that the head's 4th word transfers → trigger dropped, DropCnt+1, Level=3 afterwards. With Level=2, push and pop on the same edge → Level stays 2.
- Assert Reset during word 2 → all outputs 0 immediately. After release with no Trig, OutValid stays 0.
- With COUNT_SNAPSHOT_DELTA_EN: Cnt0=100 then 250 at two triggers → stored low words 100 and 150. With Cnt0 wrapping from 64'hFFFF_FFFF_FFFF_FFF0 to 64'h10 → delta 0x20.

Source files
------------

// File: rtl/count_snapshot.sv
// -----------------------------------------------------------------------------
// count_snapshot
//
// Captures the two 64-bit counter values on a one-cycle trigger into a small
// snapshot FIFO. Each snapshot is then streamed out as four 32-bit words over
// a valid/ready handshake. Word order within a snapshot:
//   word 0 = cnt0[31:0], word 1 = cnt0[63:32],
//   word 2 = cnt1[31:0], word 3 = cnt1[63:32] (out_last high).
//
// Optional feature (compile-time macro COUNT_SNAPSHOT_DELTA_EN):
//   defined   : each stored entry is {cnt1 - p1, cnt0 - p0} mod 2^64, where
//               p0/p1 hold the raw counter values of the last accepted
//               snapshot (reset to 0, so the first entry is absolute).
//               Dropped triggers leave p0/p1 untouched.
//   undefined : absolute counter values are stored; p0/p1 do not exist.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset (deassertion synchronized
//                   externally)
//   cnt0       in   64  counter 0 value
//   cnt1       in   64  counter 1 value
//   trig       in   snapshot request, sampled each rising edge
//   out_ready  in   downstream accepts the current word
//   out_valid  out  out_data holds a valid word
//   out_data   out  32  current word (driven from registered state only)
//   out_last   out  high with the 4th word of a snapshot
//   level      out  AW+1  occupied snapshot entries (0..DEPTH)
//   full       out  level == DEPTH
//   overflow   out  sticky: a trigger was dropped because the FIFO was full
//   drop_cnt   out  8  dropped triggers, saturating at 255
//   fsm_state  out  1  output FSM state (0 = IDLE, 1 = SEND), debug
//   word_idx   out  2  index of the word currently presented, debug
//
// Handshake: a word transfers on a rising edge where out_valid=1 and
// out_ready=1. Once out_valid is high it stays high, with out_data/out_last
// stable, until that transfer happens; out_valid never depends on out_ready.
// -----------------------------------------------------------------------------
module count_snapshot #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [63:0]   cnt0,
    input  logic [63:0]   cnt1,
    input  logic          trig,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [31:0]   out_data,
    output logic          out_last,
    output logic [AW:0]   level,
    output logic          full,
    output logic          overflow,
    output logic [7:0]    drop_cnt,
    output logic [0:0]    fsm_state,
    output logic [1:0]    word_idx
);

    localparam logic [0:0]  ST_IDLE = 1'b0;
    localparam logic [0:0]  ST_SEND = 1'b1;
    localparam logic [AW:0] LVL_MAX = (AW + 1)'(DEPTH);

    // Snapshot storage: {cnt1, cnt0} per entry.
    logic [127:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic [0:0]    state;
    logic [0:0]    state_nxt;
    logic [1:0]    widx;
    logic [127:0]  entry;
    logic [127:0]  head;

    logic push;
    logic drop;
    logic xfer;
    logic pop;

    // full is the registered value from before this edge, so a head frame
    // completing on the same edge never makes room for a trigger.
    assign push = trig & ~full;
    assign drop = trig & full;
    assign xfer = out_valid & out_ready;
    assign pop  = xfer & (widx == 2'd3);

    // -------------------------------------------------------------------------
    // Entry formation (absolute or delta)
    // -------------------------------------------------------------------------
`ifdef COUNT_SNAPSHOT_DELTA_EN
    logic [63:0] p0;
    logic [63:0] p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0 <= 64'd0;
            p1 <= 64'd0;
        end else if (push) begin
            p0 <= cnt0;
            p1 <= cnt1;
        end
    end

    assign entry = {cnt1 - p1, cnt0 - p0};
`else
    assign entry = {cnt1, cnt0};
`endif

    // -------------------------------------------------------------------------
    // FIFO storage. Not reset: contents are only observed through out_data,
    // which is forced to zero whenever no word is being presented.
    // A push never targets the head entry while it is being sent, because
    // SEND implies level >= 1 and push requires level < DEPTH.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry;
        end
    end

    // -------------------------------------------------------------------------
    // Occupancy. A partially sent head still counts until its 4th word goes.
    // -------------------------------------------------------------------------
    always_comb begin
        level_nxt = level;
        case ({push, pop})
            2'b10:   level_nxt = level + (AW + 1)'(1);
            2'b01:   level_nxt = level - (AW + 1)'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
        end else begin
            // Pointers wrap naturally because DEPTH == 2**AW.
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level <= level_nxt;
            full  <= (level_nxt == LVL_MAX);
        end
    end

    // -------------------------------------------------------------------------
    // Drop accounting (cleared only by reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
            drop_cnt <= 8'd0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output FSM
    // IDLE enters SEND one edge after level becomes non-zero, which gives the
    // one registered cycle of push-to-output latency. On the final word of a
    // frame the FSM stays in SEND if anything remains (including a same-edge
    // push), so back-to-back frames stream without a gap.
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (level != '0) begin
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                if (pop && (level_nxt == '0)) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            widx  <= 2'd0;
        end else begin
            state <= state_nxt;
            if (xfer) begin
                // Wraps 3 -> 0 on the final word of the frame.
                widx <= widx + 2'd1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Output word select. Driven only from registered state (state, widx,
    // rd_ptr, mem), so there is no path from trig or cnt0/cnt1.
    // -------------------------------------------------------------------------
    assign head = mem[rd_ptr];

    always_comb begin
        out_data = 32'd0;
        if (state == ST_SEND) begin
            case (widx)
                2'd0:    out_data = head[31:0];
                2'd1:    out_data = head[63:32];
                2'd2:    out_data = head[95:64];
                default: out_data = head[127:96];
            endcase
        end
    end

    assign out_valid = (state == ST_SEND);
    assign out_last  = (state == ST_SEND) && (widx == 2'd3);
    assign fsm_state = state;
    assign word_idx  = widx;

endmodule

// File: tb/tb_count_snapshot.sv
// -----------------------------------------------------------------------------
// tb_count_snapshot
//
// Self-checking bench for count_snapshot. Inputs are driven 1 ns after each
// rising edge; outputs are checked on the falling edge against a reference
// model built from whole-snapshot rules: an expected word queue (four words
// per accepted snapshot, oldest first), a valid flag, and drop counters.
// -----------------------------------------------------------------------------
module tb_count_snapshot;

    localparam int DEPTH = 4;
    localparam int AW    = 2;

    // ---------------------------------------------------------------- clock/reset
    logic          clk = 1'b0;
    logic          rst_n;
    logic [63:0]   cnt0;
    logic [63:0]   cnt1;
    logic          trig;
    logic          out_ready;
    logic          out_valid;
    logic [31:0]   out_data;
    logic          out_last;
    logic [AW:0]   level;
    logic          full;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic [0:0]    fsm_state;
    logic [1:0]    word_idx;

    always #5 clk = ~clk;

    count_snapshot #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt0      (cnt0),
        .cnt1      (cnt1),
        .trig      (trig),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .level     (level),
        .full      (full),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt),
        .fsm_state (fsm_state),
        .word_idx  (word_idx)
    );

    // ---------------------------------------------------------------- scoreboard
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    bit          valid_m;
    bit          ovf_m;
    int          drop_m;
    logic [63:0] p0_m;
    logic [63:0] p1_m;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        valid_m = 1'b0;
        ovf_m   = 1'b0;
        drop_m  = 0;
        p0_m    = 64'd0;
        p1_m    = 64'd0;
    endtask

    // Snapshots held = whole or partially sent frames in the word queue.
    function automatic int model_level();
        return (exp_q.size() + 3) / 4;
    endfunction

    task automatic check_outputs();
        int lvl;
        lvl = model_level();
        chk("level", 64'(lvl), 64'(level));
        chk("full", 64'(full), 64'(lvl == DEPTH));
        chk("overflow", 64'(overflow), 64'(ovf_m));
        chk("drop_cnt", 64'(drop_cnt), 64'(drop_m));
        chk("out_valid", 64'(out_valid), 64'(valid_m));
        if (valid_m && exp_q.size() != 0) begin
            chk("out_data", 64'(out_data), 64'(exp_q[0]));
            chk("out_last", 64'(out_last), 64'(exp_q.size() % 4 == 1));
        end else begin
            chk("out_data_idle", 64'(out_data), 64'd0);
            chk("out_last_idle", 64'(out_last), 64'd0);
        end
    endtask

    // Effect of the coming rising edge on the model, from the current inputs.
    task automatic model_edge();
        int          lvl_before;
        bit          popped;
        logic [63:0] d0;
        logic [63:0] d1;
        lvl_before = model_level();
        popped     = 1'b0;
        if (valid_m && out_ready) begin
            void'(exp_q.pop_front());
            popped = (exp_q.size() % 4 == 0);
        end
        if (trig) begin
            if (lvl_before == DEPTH) begin
                ovf_m = 1'b1;
                if (drop_m < 255) drop_m++;
            end else begin
`ifdef COUNT_SNAPSHOT_DELTA_EN
                d0   = cnt0 - p0_m;
                d1   = cnt1 - p1_m;
                p0_m = cnt0;
                p1_m = cnt1;
`else
                d0 = cnt0;
                d1 = cnt1;
`endif
                exp_q.push_back(d0[31:0]);
                exp_q.push_back(d0[63:32]);
                exp_q.push_back(d1[31:0]);
                exp_q.push_back(d1[63:32]);
            end
        end
        if (!valid_m) valid_m = (lvl_before != 0);
        else if (popped) valid_m = (model_level() != 0);
    endtask

    // ---------------------------------------------------------------- driver tasks
    task automatic cycle();
        @(negedge clk);
        check_outputs();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cnt();
        cnt0 = {$urandom, $urandom};
        cnt1 = {$urandom, $urandom};
    endtask

    task automatic drain();
        trig      = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200 && (exp_q.size() != 0 || valid_m); i++) cycle();
        chk("drain_level", 64'(level), 64'd0);
        chk("drain_valid", 64'(out_valid), 64'd0);
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        rst_n     = 1'b0;
        cnt0      = 64'd0;
        cnt1      = 64'd0;
        trig      = 1'b0;
        out_ready = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst_n = 1'b1;
        cycle();

        // Single snapshot, ready held high.
        cnt0      = 64'h0000_0001_0000_0002;
        cnt1      = 64'hAAAA_BBBB_CCCC_DDDD;
        trig      = 1'b1;
        out_ready = 1'b1;
        cycle();
        trig = 1'b0;
        repeat (8) cycle();

        // Five triggers into a stalled FIFO, then drain.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rand_cnt();
            trig = 1'b1;
            cycle();
        end
        trig = 1'b0;
        cycle();
        chk("fill_level", 64'(level), 64'd4);
        chk("fill_drop", 64'(drop_cnt), 64'd1);
        drain();

        // Backpressure toggling every cycle, occasional triggers.
        for (int i = 0; i < 48; i++) begin
            rand_cnt();
            out_ready = i[0];
            trig      = (i % 8 == 0);
            cycle();
        end
        drain();

        // Full FIFO, trigger on the edge the head's 4th word transfers.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rand_cnt();
            trig = 1'b1;
            cycle();
        end
        trig = 1'b0;
        cycle();
        out_ready = 1'b1;
        repeat (3) cycle();
        rand_cnt();
        trig = 1'b1;
        cycle();
        trig      = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("full_pop_drop_level", 64'(level), 64'd3);
        drain();

        // Level 2: push and pop on the same edge.
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rand_cnt();
            trig = 1'b1;
            cycle();
        end
        trig = 1'b0;
        cycle();
        out_ready = 1'b1;
        repeat (3) cycle();
        rand_cnt();
        trig = 1'b1;
        cycle();
        trig      = 1'b0;
        out_ready = 1'b0;
        cycle();
        chk("push_pop_level", 64'(level), 64'd2);
        drain();

        // Delta-oriented values (absolute in the default build).
        cnt1 = 64'd7;
        cnt0 = 64'd100;
        trig = 1'b1;
        cycle();
        cnt0 = 64'd250;
        cycle();
        cnt0 = 64'hFFFF_FFFF_FFFF_FFF0;
        cycle();
        cnt0 = 64'h10;
        cycle();
        drain();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            rand_cnt();
            trig      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 2) != 0);
            cycle();
        end
        drain();

        // Drop counter saturation.
        out_ready = 1'b0;
        trig      = 1'b1;
        for (int i = 0; i < 262; i++) begin
            rand_cnt();
            cycle();
        end
        trig = 1'b0;
        cycle();
        chk("drop_saturated", 64'(drop_cnt), 64'd255);

        // Reset during word 2 of a frame.
        out_ready = 1'b1;
        repeat (2) cycle();
        chk("pre_reset_word_idx", 64'(word_idx), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_data", 64'(out_data), 64'd0);
        chk("rst_last", 64'(out_last), 64'd0);
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_full", 64'(full), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (6) cycle();
        chk("post_reset_idle", 64'(out_valid), 64'd0);

        // ---------------------------------------------------------------- report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
